// File: rtl/rv32i_id_stage.sv
// RV32I instruction decode stage: decodes the IF/ID word, resolves source operands with
// EX/MEM forwarding, detects hazards and illegal encodings, and registers the ID/EX bundle.
module rv32i_id_stage #(
    parameter int              XLEN   = 32,
    parameter bit              FWD_EN = 1'b1,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      reg1_raddr,
    output logic [4:0]      reg2_raddr,
    input  logic [XLEN-1:0] reg1_rdata,
    input  logic [XLEN-1:0] reg2_rdata,
    input  logic            ex_wen,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_wen,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o,
    output logic            reg_wen_o,
    output logic            mem_rd_o,
    output logic            mem_wr_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign funct3     = instr_i[14:12];
    assign rs1        = instr_i[19:15];
    assign rs2        = instr_i[24:20];
    assign funct7     = instr_i[31:25];
    assign reg1_raddr = rs1;
    assign reg2_raddr = rs2;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'($signed(instr_i[31:20]));
    assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    logic use_rs1;
    logic use_rs2;

    assign use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // Per-source operand resolution: index 0 is rs1, index 1 is rs2.
    logic [4:0]      src_addr [2];
    logic [XLEN-1:0] src_rf   [2];
    logic [XLEN-1:0] src_val  [2];
    logic [1:0]      src_use;
    logic [1:0]      src_hazard;

    assign src_addr[0] = rs1;
    assign src_addr[1] = rs2;
    assign src_rf[0]   = reg1_rdata;
    assign src_rf[1]   = reg2_rdata;
    assign src_use     = {use_rs2, use_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit;
            logic mem_hit;

            assign ex_hit  = ex_wen && (ex_rd == src_addr[gi]);
            assign mem_hit = mem_wen && (mem_rd == src_addr[gi]);

            // A load in EX has no data yet, so it never forwards; that case stalls instead.
            assign src_val[gi] = (src_addr[gi] == 5'd0)              ? '0       :
                                 (FWD_EN && ex_hit && !ex_is_load)   ? ex_data  :
                                 (FWD_EN && mem_hit)                 ? mem_data :
                                                                       src_rf[gi];

            assign src_hazard[gi] = src_use[gi] && (src_addr[gi] != 5'd0) &&
                                    ((ex_hit && (ex_is_load || !FWD_EN)) || (mem_hit && !FWD_EN));
        end
    endgenerate

    logic stall;
    logic valid_reg;

    assign stall    = |src_hazard;
    assign in_ready = !stall && (!valid_reg || out_ready);

    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;
    logic [XLEN-1:0] imm_next;
    logic            illegal_next;
    logic            writes_rd;

    always_comb begin
        op1_next     = '0;
        op2_next     = '0;
        imm_next     = '0;
        illegal_next = 1'b0;
        writes_rd    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_next  = imm_u;
                op2_next  = imm_u;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                imm_next  = imm_u;
                op1_next  = pc_i;
                op2_next  = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm_next  = imm_j;
                op1_next  = pc_i;
                op2_next  = XLEN'(32'd4);
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                imm_next  = imm_i;
                op1_next  = pc_i;
                op2_next  = XLEN'(32'd4);
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                imm_next     = imm_b;
                op1_next     = src_val[0];
                op2_next     = src_val[1];
                illegal_next = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm_next     = imm_i;
                op1_next     = src_val[0];
                op2_next     = imm_i;
                writes_rd    = 1'b1;
                illegal_next = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm_next     = imm_s;
                op1_next     = src_val[0];
                op2_next     = imm_s;
                illegal_next = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                imm_next  = imm_i;
                op1_next  = src_val[0];
                op2_next  = imm_i;
                writes_rd = 1'b1;
                if (funct3 == 3'b001) begin
                    op2_next     = XLEN'(rs2);
                    illegal_next = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    op2_next     = XLEN'(rs2);
                    illegal_next = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_OP: begin
                op1_next     = src_val[0];
                op2_next     = src_val[1];
                writes_rd    = 1'b1;
                illegal_next = !((funct7 == 7'h00) ||
                                 ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: begin
                illegal_next = 1'b1;
            end
        endcase
    end

    logic accept;
    assign accept = in_valid && in_ready && !flush;

    logic [31:0]     instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] op1_reg;
    logic [XLEN-1:0] op2_reg;
    logic [XLEN-1:0] rs1_val_reg;
    logic [XLEN-1:0] rs2_val_reg;
    logic [XLEN-1:0] imm_reg;
    logic [4:0]      rd_reg;
    logic            reg_wen_reg;
    logic            mem_rd_reg;
    logic            mem_wr_reg;
    logic            branch_reg;
    logic            jump_reg;
    logic            illegal_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            instr_reg   <= '0;
            pc_reg      <= RST_PC;
            op1_reg     <= '0;
            op2_reg     <= '0;
            rs1_val_reg <= '0;
            rs2_val_reg <= '0;
            imm_reg     <= '0;
            rd_reg      <= '0;
            reg_wen_reg <= 1'b0;
            mem_rd_reg  <= 1'b0;
            mem_wr_reg  <= 1'b0;
            branch_reg  <= 1'b0;
            jump_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (in_valid && in_ready) begin
                valid_reg <= 1'b1;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
            if (accept) begin
                instr_reg   <= instr_i;
                pc_reg      <= pc_i;
                op1_reg     <= op1_next;
                op2_reg     <= op2_next;
                rs1_val_reg <= src_val[0];
                rs2_val_reg <= src_val[1];
                imm_reg     <= imm_next;
                rd_reg      <= rd;
                reg_wen_reg <= !illegal_next && writes_rd && (rd != 5'd0);
                mem_rd_reg  <= !illegal_next && (opcode == OPC_LOAD);
                mem_wr_reg  <= !illegal_next && (opcode == OPC_STORE);
                branch_reg  <= !illegal_next && (opcode == OPC_BRANCH);
                jump_reg    <= !illegal_next && ((opcode == OPC_JAL) || (opcode == OPC_JALR));
                illegal_reg <= illegal_next;
            end
        end
    end

    assign out_valid = valid_reg;
    assign instr_o   = instr_reg;
    assign pc_o      = pc_reg;
    assign op1_o     = op1_reg;
    assign op2_o     = op2_reg;
    assign rs1_val_o = rs1_val_reg;
    assign rs2_val_o = rs2_val_reg;
    assign imm_o     = imm_reg;
    assign rd_o      = rd_reg;
    assign reg_wen_o = reg_wen_reg;
    assign mem_rd_o  = mem_rd_reg;
    assign mem_wr_o  = mem_wr_reg;
    assign branch_o  = branch_reg;
    assign jump_o    = jump_reg;
    assign illegal_o = illegal_reg;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Bench for rv32i_id_stage: directed scenarios followed by randomized traffic, all checked
// against an instruction-level reference model of decode, forwarding and handshake.
module tb_rv32i_id_stage;

    localparam logic [31:0] TB_RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [4:0]  reg1_raddr;
    logic [4:0]  reg2_raddr;
    logic [31:0] reg1_rdata;
    logic [31:0] reg2_rdata;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_is_load;
    logic        mem_wen;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] rs1_val_o;
    logic [31:0] rs2_val_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o;
    logic        reg_wen_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic        branch_o;
    logic        jump_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    rv32i_id_stage #(
        .XLEN   (32),
        .FWD_EN (1'b1),
        .RST_PC (TB_RST_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .reg1_raddr (reg1_raddr),
        .reg2_raddr (reg2_raddr),
        .reg1_rdata (reg1_rdata),
        .reg2_rdata (reg2_rdata),
        .ex_wen     (ex_wen),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_is_load (ex_is_load),
        .mem_wen    (mem_wen),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .op1_o      (op1_o),
        .op2_o      (op2_o),
        .rs1_val_o  (rs1_val_o),
        .rs2_val_o  (rs2_val_o),
        .imm_o      (imm_o),
        .rd_o       (rd_o),
        .reg_wen_o  (reg_wen_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .branch_o   (branch_o),
        .jump_o     (jump_o),
        .illegal_o  (illegal_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [31:0] rd;
        logic [31:0] reg_wen;
        logic [31:0] mem_rd;
        logic [31:0] mem_wr;
        logic [31:0] branch;
        logic [31:0] jump;
        logic [31:0] illegal;
    } bundle_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rf [32];
    bit          exp_valid;
    bundle_t     exp_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Value of architectural register r as the decode stage should see it right now.
    function automatic logic [31:0] model_src(input int r);
        if (r == 0) return 32'h0;
        if (ex_wen && !ex_is_load && int'(ex_rd) == r) return ex_data;
        if (mem_wen && int'(mem_rd) == r) return mem_data;
        return rf[r];
    endfunction

    function automatic bit uses_rs1(input int op);
        return !(op == 'h37 || op == 'h17 || op == 'h6f);
    endfunction

    function automatic bit uses_rs2(input int op);
        return (op == 'h33 || op == 'h23 || op == 'h63);
    endfunction

    function automatic bit model_stall(input logic [31:0] w);
        int op;
        int s1;
        int s2;
        op = int'(w & 32'h7f);
        s1 = int'((w >> 15) & 32'h1f);
        s2 = int'((w >> 20) & 32'h1f);
        if (!(ex_wen && ex_is_load) || ex_rd == 5'd0) return 1'b0;
        return (uses_rs1(op) && s1 == int'(ex_rd)) || (uses_rs2(op) && s2 == int'(ex_rd));
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t     b;
        int          op;
        int          f3;
        int          f7;
        int          rd;
        int signed   sw;
        logic [31:0] ii;
        logic [31:0] is;
        logic [31:0] ib;
        logic [31:0] iu;
        logic [31:0] ij;
        bit          wr;
        op = int'(w & 32'h7f);
        f3 = int'((w >> 12) & 32'h7);
        f7 = int'(w >> 25);
        rd = int'((w >> 7) & 32'h1f);
        sw = $signed(w);
        ii = 32'(sw >>> 20);
        is = 32'((sw >>> 25) <<< 5) | ((w >> 7) & 32'h1f);
        ib = 32'((sw >>> 31) <<< 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3f) << 5)
             | (((w >> 8) & 32'hf) << 1);
        iu = w & 32'hFFFF_F000;
        ij = 32'((sw >>> 31) <<< 20) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11)
             | (((w >> 21) & 32'h3ff) << 1);
        b = '{instr: w, pc: pc, op1: 0, op2: 0, rs1v: model_src(int'((w >> 15) & 32'h1f)),
              rs2v: model_src(int'((w >> 20) & 32'h1f)), imm: 0, rd: 32'(rd), reg_wen: 0,
              mem_rd: 0, mem_wr: 0, branch: 0, jump: 0, illegal: 0};
        wr = 1'b0;
        case (op)
            'h37: begin b.imm = iu; b.op2 = iu; wr = 1'b1; end
            'h17: begin b.imm = iu; b.op1 = pc; b.op2 = iu; wr = 1'b1; end
            'h6f: begin b.imm = ij; b.op1 = pc; b.op2 = 4; wr = 1'b1; b.jump = 1; end
            'h67: begin b.imm = ii; b.op1 = pc; b.op2 = 4; wr = 1'b1; b.jump = 1; end
            'h63: begin
                b.imm = ib; b.op1 = b.rs1v; b.op2 = b.rs2v; b.branch = 1;
                b.illegal = 32'(f3 == 2 || f3 == 3);
            end
            'h03: begin
                b.imm = ii; b.op1 = b.rs1v; b.op2 = ii; wr = 1'b1; b.mem_rd = 1;
                b.illegal = 32'(f3 == 3 || f3 == 6 || f3 == 7);
            end
            'h23: begin
                b.imm = is; b.op1 = b.rs1v; b.op2 = is; b.mem_wr = 1;
                b.illegal = 32'(f3 > 2);
            end
            'h13: begin
                b.imm = ii; b.op1 = b.rs1v; b.op2 = ii; wr = 1'b1;
                if (f3 == 1 || f3 == 5) b.op2 = (w >> 20) & 32'h1f;
                if (f3 == 1) b.illegal = 32'(f7 != 0);
                if (f3 == 5) b.illegal = 32'(f7 != 0 && f7 != 'h20);
            end
            'h33: begin
                b.op1 = b.rs1v; b.op2 = b.rs2v; wr = 1'b1;
                b.illegal = 32'(!(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))));
            end
            default: b.illegal = 1;
        endcase
        b.reg_wen = 32'(wr && rd != 0);
        if (b.illegal != 0) begin
            b.reg_wen = 0; b.mem_rd = 0; b.mem_wr = 0; b.branch = 0; b.jump = 0;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'h37;
            1: op = 7'h17;
            2: op = 7'h6f;
            3: op = 7'h67;
            4: op = 7'h63;
            5: op = 7'h03;
            6: op = 7'h23;
            7: op = 7'h13;
            8: op = 7'h33;
            default: op = 7'($urandom);
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (op == 7'h33 || op == 7'h13) begin
            case ($urandom_range(0, 4))
                0, 1:    w[31:25] = 7'h00;
                2, 3:    w[31:25] = 7'h20;
                default: w[31:25] = w[31:25];
            endcase
        end
        return w;
    endfunction

    task automatic check_bundle();
        check_eq("instr_o", instr_o, exp_b.instr);
        check_eq("pc_o", pc_o, exp_b.pc);
        check_eq("op1_o", op1_o, exp_b.op1);
        check_eq("op2_o", op2_o, exp_b.op2);
        check_eq("rs1_val_o", rs1_val_o, exp_b.rs1v);
        check_eq("rs2_val_o", rs2_val_o, exp_b.rs2v);
        check_eq("imm_o", imm_o, exp_b.imm);
        check_eq("rd_o", 32'(rd_o), exp_b.rd);
        check_eq("reg_wen_o", 32'(reg_wen_o), exp_b.reg_wen);
        check_eq("mem_rd_o", 32'(mem_rd_o), exp_b.mem_rd);
        check_eq("mem_wr_o", 32'(mem_wr_o), exp_b.mem_wr);
        check_eq("branch_o", 32'(branch_o), exp_b.branch);
        check_eq("jump_o", 32'(jump_o), exp_b.jump);
        check_eq("illegal_o", 32'(illegal_o), exp_b.illegal);
    endtask

    // Inputs are set just after a posedge; this checks the combinational side, advances one
    // clock and checks the registered side against the model.
    task automatic run_cycle();
        bit exp_ready;
        bit acc;
        reg1_rdata = rf[instr_i[19:15]];
        reg2_rdata = rf[instr_i[24:20]];
        #2;
        exp_ready = !model_stall(instr_i) && (!exp_valid || out_ready);
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("reg1_raddr", 32'(reg1_raddr), (instr_i >> 15) & 32'h1f);
        check_eq("reg2_raddr", 32'(reg2_raddr), (instr_i >> 20) & 32'h1f);
        acc = in_valid && exp_ready;
        if (flush) begin
            exp_valid = 1'b0;
        end else if (acc) begin
            exp_valid = 1'b1;
            exp_b     = model_decode(instr_i, pc_i);
            $display("[TB] txn pc=%08h instr=%08h", pc_i, instr_i);
        end else if (out_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) check_bundle();
    endtask

    task automatic quiet_side();
        ex_wen     = 1'b0;
        ex_rd      = 5'd0;
        ex_data    = 32'h0;
        ex_is_load = 1'b0;
        mem_wen    = 1'b0;
        mem_rd     = 5'd0;
        mem_data   = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0]      = 32'hDEAD_BEEF;
        rf[1]      = 32'h0000_0010;
        pc_i       = 32'h0000_2000;
        instr_i    = 32'hFFF0_8293;
        reg1_rdata = 32'h0;
        reg2_rdata = 32'h0;
        quiet_side();

        // Reset held two cycles with in_valid asserted.
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_pc_o", pc_o, TB_RST_PC);
        check_eq("rst_op1_o", op1_o, 32'h0);
        check_eq("rst_instr_o", instr_o, 32'h0);
        check_eq("rst_reg_wen_o", 32'(reg_wen_o), 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        instr_i  = 32'h0000_0013;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        exp_valid = 1'b0;
        @(posedge clk); #1;

        // ADDI x5,x1,-1 with x1=0x10.
        quiet_side();
        instr_i = 32'hFFF0_8293;
        run_cycle();
        check_eq("addi_op1", op1_o, 32'h0000_0010);
        check_eq("addi_op2", op2_o, 32'hFFFF_FFFF);
        check_eq("addi_rd", 32'(rd_o), 32'd5);
        check_eq("addi_wen", 32'(reg_wen_o), 32'h1);

        // ADD x4,x3,x3 with EX and MEM both writing x3: EX wins, then MEM when EX targets x0.
        quiet_side();
        ex_wen   = 1'b1; ex_rd = 5'd3; ex_data = 32'hAA;
        mem_wen  = 1'b1; mem_rd = 5'd3; mem_data = 32'hBB;
        instr_i  = 32'h0031_8233;
        pc_i     = 32'h0000_2004;
        run_cycle();
        check_eq("fwd_ex_op1", op1_o, 32'hAA);
        check_eq("fwd_ex_op2", op2_o, 32'hAA);
        ex_rd = 5'd0;
        run_cycle();
        check_eq("fwd_mem_op1", op1_o, 32'hBB);
        check_eq("fwd_mem_op2", op2_o, 32'hBB);

        // Load-use: LW x7 in EX, decode ADD x8,x7,x1.
        quiet_side();
        ex_wen = 1'b1; ex_rd = 5'd7; ex_is_load = 1'b1; ex_data = 32'h1234;
        instr_i = 32'h0013_8433;
        pc_i    = 32'h0000_2008;
        run_cycle();
        check_eq("lu_stall", 32'(in_ready), 32'h0);
        ex_wen = 1'b0; ex_is_load = 1'b0;
        mem_wen = 1'b1; mem_rd = 5'd7; mem_data = 32'h55;
        run_cycle();
        check_eq("lu_op1", op1_o, 32'h55);
        check_eq("lu_rd", 32'(rd_o), 32'd8);

        // Back-pressure: hold for three cycles, then flush the held bundle.
        quiet_side();
        instr_i = 32'hFFF0_8293;
        pc_i    = 32'h0000_200C;
        run_cycle();
        out_ready = 1'b0;
        instr_i   = 32'h1234_5037;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check_eq("hold_in_ready", 32'(in_ready), 32'h0);
            check_eq("hold_instr_o", instr_o, 32'hFFF0_8293);
        end
        flush = 1'b1;
        run_cycle();
        check_eq("flush_valid", 32'(out_valid), 32'h0);

        // Illegal encodings and a write to x0.
        quiet_side();
        instr_i = 32'h0000_007F;
        run_cycle();
        check_eq("ill_opc", 32'(illegal_o), 32'h1);
        check_eq("ill_opc_wen", 32'(reg_wen_o), 32'h0);
        check_eq("ill_opc_wr", 32'(mem_wr_o), 32'h0);
        instr_i = 32'h2030_D293;
        run_cycle();
        check_eq("ill_srai", 32'(illegal_o), 32'h1);
        check_eq("ill_srai_wen", 32'(reg_wen_o), 32'h0);
        instr_i = 32'h1234_5037;
        run_cycle();
        check_eq("lui_x0_wen", 32'(reg_wen_o), 32'h0);
        check_eq("lui_x0_ill", 32'(illegal_o), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 9) < 8);
            instr_i    = rand_instr();
            pc_i       = $urandom & 32'hFFFF_FFFC;
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            ex_wen     = $urandom_range(0, 1) == 1;
            ex_rd      = 5'($urandom_range(0, 7));
            ex_data    = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            mem_wen    = $urandom_range(0, 1) == 1;
            mem_rd     = 5'($urandom_range(0, 7));
            mem_data   = $urandom;
            rf[$urandom_range(1, 31)] = $urandom;
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
